// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (double dabble) feeding a time-multiplexed 7-segment digit bus.
// Optional macro BCD_SCAN_LZ_BLANK_EN blanks leading zero digits at load time.
module bcd_scan_driver #(
    parameter int BIN_W    = 14,
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIN_W-1:0]  in_data,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [3:0]        dig,
    output logic [NDIG-1:0]   an_n
);

    // Accumulator holds every decimal digit BIN_W bits can produce, so large inputs shift cleanly.
    localparam int BCDN  = (NDIG > (BIN_W + 2) / 3) ? NDIG : (BIN_W + 2) / 3;
    localparam int BCDW  = 4 * BCDN;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam longint unsigned MAXI = 64'(10 ** NDIG) - 64'd1;
    localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAXI);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t              state;
    logic [BIN_W-1:0]    bin;
    logic [BCDW-1:0]     bcd;
    logic [BCDW-1:0]     adj;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_pend;
    logic [4*NDIG-1:0]   disp;
    logic [4*NDIG-1:0]   ld_disp;
    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    idx;
`ifdef BCD_SCAN_LZ_BLANK_EN
    logic                lead;
`endif

    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < BCDN; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
    end

    always_comb begin
        ld_disp = '1;
`ifdef BCD_SCAN_LZ_BLANK_EN
        lead = 1'b1;
`endif
        if (!ovf_pend) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                ld_disp[4*i +: 4] = bcd[4*i +: 4];
            end
`ifdef BCD_SCAN_LZ_BLANK_EN
            for (int unsigned i = NDIG - 1; i >= 1; i--) begin
                if (lead && ld_disp[4*i +: 4] == 4'd0) begin
                    ld_disp[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            disp     <= '1;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_valid && in_ready) begin
                        bin      <= in_data;
                        bcd      <= '0;
                        cnt      <= '0;
                        ovf_pend <= (in_data > MAXV);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    {bcd, bin} <= {adj[BCDW-2:0], bin, 1'b0};
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        busy  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    disp     <= ld_disp;
                    ovf      <= ovf_pend;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        an_n = '1;
        dig  = 4'hF;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) begin
                an_n[i] = 1'b0;
                dig     = disp[4*i +: 4];
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver: expected display/ovf queued on acceptance, popped on done.
module tb_bcd_scan_driver;

    localparam int BIN_W    = 14;
    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [BIN_W-1:0]  in_data;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [3:0]        dig;
    logic [NDIG-1:0]   an_n;

    bcd_scan_driver #(.BIN_W(BIN_W), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .done(done), .ovf(ovf), .dig(dig), .an_n(an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4*NDIG-1:0] disp;
        logic              ovf;
    } exp_t;

    exp_t              q[$];
    exp_t              mon_e;
    logic [4*NDIG-1:0] cur_disp;
    int                total = 0;
    int                bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*NDIG-1:0] model(input int unsigned v);
        logic [4*NDIG-1:0] r;
        bit lead;
        r = '1;
        lead = 1'b1;
        if (v <= 10 ** NDIG - 1) begin
            for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
`ifdef BCD_SCAN_LZ_BLANK_EN
            for (int i = NDIG - 1; i >= 1; i--) begin
                if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`endif
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("ovf", 32'(ovf), 32'(mon_e.ovf));
                    cur_disp = mon_e.disp;
                end
            end
        end
    end

    task automatic accept(input int unsigned v, output int tries);
        logic r;
        bit ok;
        ok = 1'b0;
        tries = 0;
        in_data = BIN_W'(v);
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
            tries++;
        end
        if (ok) q.push_back(exp_t'{model(v), (v > 10 ** NDIG - 1)});
        else check("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    // already = cycles elapsed since acceptance edge; in_ready assumed low for all of them
    task automatic wait_done(input int already);
        int low;
        bit seen;
        seen = 1'b0;
        low = already + 1;
        if (already == 0) check("ready_drop", 32'(in_ready), 32'd0);
        for (int k = already + 1; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("busy", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                check("latency", 32'(k), 32'(BIN_W + 1));
                check("ready_low_cycles", 32'(low), 32'(BIN_W + 1));
                check("ready_back", 32'(in_ready), 32'd1);
                break;
            end
            if (!in_ready) low++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_display();
        logic [3:0] got[NDIG];
        int zeros;
        int pos;
        for (int i = 0; i < NDIG; i++) got[i] = 4'hX;
        for (int c = 0; c < NDIG * SCAN_DIV; c++) begin
            @(negedge clk);
            zeros = 0;
            pos = 0;
            for (int i = 0; i < NDIG; i++) begin
                if (!an_n[i]) begin
                    zeros++;
                    pos = i;
                end
            end
            check("an_onehot", 32'(zeros), 32'd1);
            got[pos] = dig;
        end
        for (int i = 0; i < NDIG; i++)
            check($sformatf("dig%0d", i), 32'(got[i]), 32'(cur_disp[4*i +: 4]));
    endtask

    task automatic run(input int unsigned v);
        int t;
        accept(v, t);
        wait_done(0);
        read_display();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [NDIG-1:0] ea;
        int t;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        cur_disp = '1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_dig", 32'(dig), 32'hF);
        check("rst_an", 32'(an_n), 32'hE);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5 * SCAN_DIV; k++) begin
            if (k > 0) @(negedge clk);
            ea = '1;
            ea[(k / SCAN_DIV) % NDIG] = 1'b0;
            check("scan_an", 32'(an_n), 32'(ea));
            check("scan_dig", 32'(dig), 32'hF);
            check("scan_ready", 32'(in_ready), 32'd1);
        end

        run(1234);
        run(9999);
        run(10000);
        run(0);
        run(16383);
        run(42);
        run(1005);

        // back-to-back: second value accepted on the first edge in_ready is high
        accept(300, t);
        wait_done(0);
        accept(301, t);
        check("b2b_tries", 32'(t), 32'd0);
        wait_done(0);
        read_display();

        // value presented mid-conversion is ignored
        accept(1234, t);
        repeat (2) @(posedge clk);
        #1;
        in_data = BIN_W'(5678);
        in_valid = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check("hs_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        wait_done(10);
        read_display();
        run(5678);

        // reset mid-conversion
        accept(4321, t);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        cur_disp = '1;
        check("mr_ready", 32'(in_ready), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_an", 32'(an_n), 32'hE);
        check("mr_dig", 32'(dig), 32'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            check("mr_no_done", 32'(done), 32'd0);
        end
        read_display();
        run(77);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Upstream feeder for the 4-bit digit decoder (active-low segments; codes 10..15 blank).
- Accepts a binary value over a valid/ready handshake and converts it to BCD sequentially using shift-add-3 (double dabble).
- Latches the resulting digits into a display register.
- Time-multiplexes the digits onto a shared 4-bit digit bus with active-low digit enables, for a common multiplexed 7-segment display.

Parameters:
- BIN_W, 14, binary input width; 2^BIN_W-1 must be at least 10^NDIG-1.
- NDIG, 4, number of display digits, range 1..8.
- SCAN_DIV, 50000, clock cycles each digit stays enabled; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a value.
- in_data  input  BIN_W  unsigned binary value to display.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when the display register is updated.
- ovf  output  1  last accepted value exceeded 10^NDIG-1; sticky until the next accepted value.
- dig  output  4  BCD digit for the currently enabled position; feeds the decoder's dec input.
- an_n  output  NDIG  active-low one-hot digit enable; bit 0 is the least significant digit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM to IDLE; in_ready=1; busy=0; done=0; ovf=0.
  - Every display digit = 4'hF (blank); scan index = 0; divider = 0.
  - Therefore an_n = all ones except bit0=0, and dig = 4'hF.
- Reset asserted mid-conversion aborts it; the display returns to blank.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready, capture in_data into the shift register, clear the BCD accumulator, go to CONV.
  - CONV: busy=1, in_ready=0. Runs exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one. After BIN_W cycles go to LOAD.
  - LOAD: one cycle. Writes the display register and ovf, pulses done=1, then returns to IDLE.
- Latency: a value accepted at edge N appears on the display register, with done=1, in the cycle after edge N+BIN_W+1.
- Back-to-back acceptance is possible at edge N+BIN_W+2.
- in_valid while in_ready=0 is ignored; there is no queuing. The upstream block must hold in_valid until accepted.
- Overflow: if the captured value > 10^NDIG-1, LOAD writes 4'hF to all digits and sets ovf=1. Otherwise it writes the BCD digits and clears ovf.
  - The comparison uses the captured value, not the BCD carry-out.
- The BCD accumulator is NDIG*4 bits plus enough guard bits that an overflowing value never corrupts the comparison.
- Scan:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the scan index increments modulo NDIG (NDIG-1 wraps to 0).
  - SCAN_DIV=1 advances the index every cycle.
- an_n and dig are combinational from the registered scan index and the display register.
  - an_n[i]=0 iff index==i; exactly one bit is low at all times after reset.
  - dig = display[index].
- Display update mid-scan: the new digits are visible from the cycle after LOAD. The scan index and divider are not disturbed.
- The scan runs continuously, independent of the FSM; no gaps during conversion.

Optional Feature:
- Macro: BCD_SCAN_LZ_BLANK_EN.
- Defined:
  - At LOAD, leading zero digits (from the most significant digit downward, stopping at the first non-zero digit) are written as 4'hF.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - ovf behaviour is unchanged.
- Undefined: all NDIG digits are shown, including leading zeros.

Test Plan:
- Reset/scan (NDIG=4, SCAN_DIV=3):
  - Release rst_n with no input -> an_n cycles 1110, 1101, 1011, 0111, 1110, each held 3 cycles.
  - dig=4'hF throughout; in_ready=1.
- Conversion (BIN_W=14, in_data=1234, single valid pulse):
  - in_ready low for 15 cycles; done pulses exactly 15 cycles after acceptance; ovf=0.
  - During scan, dig reads 4, 3, 2, 1 with an_n 1110, 1101, 1011, 0111 respectively.
- Boundaries:
  - in_data=9999 -> digits 9,9,9,9; ovf=0.
  - in_data=10000 -> all digits 4'hF; ovf=1.
  - in_data=0 -> digits 0,0,0,0 (macro undefined); ovf=0.
- Handshake:
  - Assert in_valid with 5678 during a 1234 conversion -> ignored; display shows 1234.
  - Re-present 5678 after in_ready returns -> display shows 5678.
- Mid-operation reset: assert rst_n low 7 cycles into a conversion -> no done pulse; digits blank; an_n=1110; in_ready=1 immediately.
- BCD_SCAN_LZ_BLANK_EN defined:
  - in_data=42 -> digits F,F,4,2 (MSD to LSD).
  - in_data=0 -> F,F,F,0.
  - in_data=1005 -> 1,0,0,5.
